sim_ddr_model: RTL

- Parametrised, cycle-accurate simulation model of external DDR behind a 1-command-per-cycle valid/ready port.
- Generalises width, depth and latency, and adds:
  - synchronous reset;
  - command backpressure;
  - an outstanding-read limit;
  - periodic refresh stalls;
  - sticky error reporting for unaligned or out-of-range accesses.
- Used in testbenches and simulation builds in place of the real DDR controller.

---
 rtl/sim_ddr_pkg.sv | 25 ++
 rtl/sim_ddr_rsp_pipe.sv | 35 +++
 rtl/sim_ddr_model.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/sim_ddr_pkg.sv
// Shared types and sizing helpers for the simulation DDR model.
package sim_ddr_pkg;

  typedef enum logic {RefRun, RefStall} ref_state_e;

  localparam int DefDataWidth = 64;
  localparam int DefAddrWidth = 32;

  function automatic int lane_count(input int data_width);
    return data_width / 8;
  endfunction

  function automatic int offset_bits(input int data_width);
    int b = 0;
    for (int i = 0; i < 16; i++) begin
      if ((1 << i) < lane_count(data_width)) b = i + 1;
    end
    return b;
  endfunction

  function automatic logic [63:0] word_index(input logic [63:0] addr, input int data_width);
    return addr >> offset_bits(data_width);
  endfunction

endpackage

// File: rtl/sim_ddr_rsp_pipe.sv
// Fixed-latency read response pipeline; the last stage keeps its data between responses.
module sim_ddr_rsp_pipe #(
  parameter int DataWidth = 64,
  parameter int Latency   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 vld_i,
  input  logic [DataWidth-1:0] data_i,
  output logic                 vld_o,
  output logic [DataWidth-1:0] data_o
);

  logic [Latency-1:0]   vld_q;
  logic [DataWidth-1:0] data_q [Latency];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q <= '0;
      for (int i = 0; i < Latency; i++) data_q[i] <= '0;
    end else begin
      vld_q[0] <= vld_i;
      if (vld_i) data_q[0] <= data_i;
      // Data only moves with its valid bit, so each stage holds the last response.
      for (int i = 1; i < Latency; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) data_q[i] <= data_q[i-1];
      end
    end
  end

  assign vld_o  = vld_q[Latency-1];
  assign data_o = data_q[Latency-1];

endmodule

// File: rtl/sim_ddr_model.sv
// Cycle-accurate DDR stand-in: byte-lane RAM, fixed read latency, outstanding limit,
// optional periodic refresh stalls and sticky error capture.
module sim_ddr_model
  import sim_ddr_pkg::*;
#(
  parameter int DataWidth       = DefDataWidth,
  parameter int AddrWidth       = DefAddrWidth,
  parameter int Depth           = 256,
  parameter int ReadLatency     = 16,
  parameter int MaxOutstanding  = 8,
  parameter int RefreshInterval = 0,
  parameter int RefreshCycles   = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                cmd_valid_i,
  output logic                                cmd_ready_o,
  input  logic                                cmd_write_i,
  input  logic [AddrWidth-1:0]                addr_i,
  input  logic [DataWidth-1:0]                data_i,
  input  logic [DataWidth/8-1:0]              byte_en_i,
  output logic                                rsp_valid_o,
  output logic [DataWidth-1:0]                data_o,
  output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o,
  output logic                                err_o,
  output logic [AddrWidth-1:0]                err_addr_o
);

  localparam int Lanes = lane_count(DataWidth);
  localparam int IdxW  = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int OutW  = $clog2(MaxOutstanding + 1);
  localparam int RefW  = $clog2(((RefreshInterval > RefreshCycles) ? RefreshInterval : RefreshCycles) + 1);

  logic                 rst_q;
  logic [OutW-1:0]      out_q, out_d;
  logic                 err_q, err_d;
  logic [AddrWidth-1:0] err_addr_q, err_addr_d;
  ref_state_e           ref_q, ref_d;
  logic [RefW-1:0]      ref_cnt_q, ref_cnt_d;

  logic                 refreshing, accept, bad, wr_acc, rd_acc;
  logic [63:0]          widx;
  logic [IdxW-1:0]      idx;
  logic [DataWidth-1:0] rd_data;

  assign widx  = word_index(64'(addr_i), DataWidth);
  assign idx   = widx[IdxW-1:0];
  assign bad   = ((addr_i & AddrWidth'(Lanes - 1)) != '0) || (widx >= 64'(Depth));

  assign refreshing  = (RefreshInterval > 0) && (ref_q == RefStall);
  assign cmd_ready_o = !rst_q && !refreshing && (out_q < OutW'(MaxOutstanding));
  assign accept      = cmd_valid_i && cmd_ready_o;
  assign wr_acc      = accept && cmd_write_i && !bad;
  assign rd_acc      = accept && !cmd_write_i;

  // Byte-lane storage; errored reads return zero instead of array contents.
  for (genvar b = 0; b < Lanes; b++) begin : g_lane
    logic [7:0] lane_q [Depth];
    always_ff @(posedge clk_i) begin
      if (wr_acc && byte_en_i[b]) lane_q[idx] <= data_i[8*b +: 8];
    end
    assign rd_data[8*b +: 8] = bad ? 8'h00 : lane_q[idx];
  end

  sim_ddr_rsp_pipe #(
    .DataWidth (DataWidth),
    .Latency   (ReadLatency)
  ) u_rsp_pipe (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .vld_i  (rd_acc),
    .data_i (rd_data),
    .vld_o  (rsp_valid_o),
    .data_o (data_o)
  );

  always_comb begin
    out_d      = out_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    ref_d      = ref_q;
    ref_cnt_d  = ref_cnt_q;

    if (rd_acc && !rsp_valid_o)      out_d = out_q + OutW'(1);
    else if (!rd_acc && rsp_valid_o) out_d = out_q - OutW'(1);

    if (accept && bad) begin
      err_d = 1'b1;
      if (!err_q) err_addr_d = addr_i;
    end

    if (RefreshInterval > 0) begin
      case (ref_q)
        RefRun: begin
          if (ref_cnt_q == RefW'(RefreshInterval - 1)) begin
            ref_d     = RefStall;
            ref_cnt_d = '0;
          end else begin
            ref_cnt_d = ref_cnt_q + RefW'(1);
          end
        end
        RefStall: begin
          if (ref_cnt_q == RefW'(RefreshCycles - 1)) begin
            ref_d     = RefRun;
            ref_cnt_d = '0;
          end else begin
            ref_cnt_d = ref_cnt_q + RefW'(1);
          end
        end
        default: ref_d = RefRun;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rst_q      <= 1'b1;
      out_q      <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
      ref_q      <= RefRun;
      ref_cnt_q  <= '0;
    end else begin
      rst_q      <= 1'b0;
      out_q      <= out_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
      ref_q      <= ref_d;
      ref_cnt_q  <= ref_cnt_d;
    end
  end

  assign outstanding_o = out_q;
  assign err_o         = err_q;
  assign err_addr_o    = err_addr_q;

`ifndef SYNTHESIS
  // A stalled command must be held unchanged until it is taken.
  a_cmd_hold: assert property (@(posedge clk_i) disable iff (rst_i)
    (cmd_valid_i && !cmd_ready_o) |=>
      (cmd_valid_i && $stable({cmd_write_i, addr_i, data_i, byte_en_i})));
`endif

endmodule
